// File: rtl/fir_bank_sequencer_pkg.sv
// Package: fir_bank_sequencer_pkg
// Purpose: shared types and constants for the FIR bank sequencer and its MAC.
//   - seq_state_e : sequencer states (IDLE / RUN / FLUSH)
//   - widths      : ring depth, sample, coefficient, product and output widths
//   - fit_y       : maps the wide accumulator onto the 18-bit output, either
//                   by plain truncation (wrap) or by clamping to the Y_W range.
package fir_bank_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_e;

  localparam int RING_DEPTH = 32;
  localparam int PTR_W      = 5;
  localparam int SAMPLE_W   = 8;
  localparam int COEFF_W    = 10;
  localparam int PROD_W     = 18;
  localparam int Y_W        = 18;

  // Wide accumulator value -> output word; sat_en selects clamp vs wrap.
  function automatic logic [Y_W-1:0] fit_y(input logic signed [31:0] v,
                                           input logic sat_en);
    logic [Y_W-1:0] r;
    if (sat_en && (v > 32'sd131071)) begin
      r = 18'h1FFFF;
    end else if (sat_en && (v < -32'sd131072)) begin
      r = 18'h20000;
    end else begin
      r = v[Y_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_bank_sequencer_mac.sv
// Module: fir_mac
// Purpose: registered 8x10 signed multiply followed by a signed accumulate.
//   The product of cycle n is added into the accumulator in cycle n+1, so the
//   combinational acc_sum (acc + sign-extended prod) is the value the
//   accumulator would take next; the sequencer reads it during FLUSH.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   clear        : zero product and accumulator on the next edge
//   enable       : load a new product and fold the previous one into acc
//   sample       : signed 8-bit operand
//   coeff        : signed 10-bit operand
//   acc_sum      : acc + sext(prod), ACC_W bits signed
module fir_mac
  import fir_bank_sequencer_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       enable,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic signed [COEFF_W-1:0]  coeff,
  output logic signed [ACC_W-1:0]    acc_sum
);

  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  // Next product/accumulator: clear wins over enable, otherwise hold.
  always_comb begin
    acc_sum = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    prod_d  = prod_q;
    acc_d   = acc_q;
    if (clear) begin
      prod_d = {PROD_W{1'b0}};
      acc_d  = {ACC_W{1'b0}};
    end else if (enable) begin
      prod_d = PROD_W'(sample) * PROD_W'(coeff);
      acc_d  = acc_sum;
    end else begin
      prod_d = prod_q;
      acc_d  = acc_q;
    end
  end

  // Product and accumulator registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      prod_q <= {PROD_W{1'b0}};
      acc_q  <= {ACC_W{1'b0}};
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/fir_bank_sequencer.sv
// Module: fir_bank_sequencer
// Purpose: time-multiplexes one MAC across NBANDS FIR filters of NTAPS taps.
//   Each accepted sample goes into a 32-entry ring; the sequencer then walks
//   tap 0..NTAPS-1 for band 0, flushes, and repeats for each band. Each band
//   takes NTAPS+1 cycles and produces one y_valid pulse.
// Optional feature: define FIR_SEQ_SATURATE_EN to clamp y instead of wrapping.
// Ports:
//   clock, reset  : clock and synchronous active-high reset
//   ready, x      : new-sample strobe and signed sample
//   coeff_index   : tap index to the coefficient ROM (0 outside RUN)
//   band_sel      : band select to the ROM mux (0 outside RUN)
//   coeff         : signed coefficient, combinational from the ROM
//   y, y_band     : filter output and the band it belongs to
//   y_valid       : one-cycle strobe when y/y_band update
//   busy          : high while a sample is being sequenced
//   overrun       : one-cycle strobe, a sample arrived while busy and was dropped
module fir_bank_sequencer
  import fir_bank_sequencer_pkg::*;
#(
  parameter int NBANDS = 4,
  parameter int NTAPS  = 31,
  parameter int ACC_W  = 24
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ready,
  input  logic [SAMPLE_W-1:0] x,
  output logic [4:0]          coeff_index,
  output logic [2:0]          band_sel,
  input  logic [COEFF_W-1:0]  coeff,
  output logic [Y_W-1:0]      y,
  output logic [2:0]          y_band,
  output logic                y_valid,
  output logic                busy,
  output logic                overrun
);

`ifdef FIR_SEQ_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  localparam logic [PTR_W-1:0] TAP_LAST  = PTR_W'(NTAPS - 1);
  localparam logic [2:0]       BAND_LAST = 3'(NBANDS - 1);

  seq_state_e            state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      tap_q, tap_d;
  logic [2:0]            band_q, band_d;
  logic [2:0]            band_sel_q, band_sel_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [2:0]            y_band_q, y_band_d;
  logic                  y_valid_q, y_valid_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic [SAMPLE_W-1:0]   ring_q [RING_DEPTH];
  logic                  ring_we;
  logic                  mac_clear, mac_en;
  logic [PTR_W-1:0]      rd_ptr;
  logic signed [ACC_W-1:0] acc_sum;
  logic                  last_tap, last_band;

  // Newest sample sits at wr_ptr-1; tap k reads k samples further back.
  assign rd_ptr    = wr_ptr_q - 5'd1 - tap_q;
  assign last_tap  = (tap_q == TAP_LAST);
  assign last_band = (band_q == BAND_LAST);

  fir_mac #(.ACC_W(ACC_W)) u_mac (
    .clock   (clock),
    .reset   (reset),
    .clear   (mac_clear),
    .enable  (mac_en),
    .sample  (ring_q[rd_ptr]),
    .coeff   (coeff),
    .acc_sum (acc_sum)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ready)     state_d = ST_RUN;   else state_d = ST_IDLE;
      ST_RUN:   if (last_tap)  state_d = ST_FLUSH; else state_d = ST_RUN;
      ST_FLUSH: if (last_band) state_d = ST_IDLE;  else state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath control and output next-values.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    tap_d     = tap_q;
    band_d    = band_q;
    y_d       = y_q;
    y_band_d  = y_band_q;
    y_valid_d = 1'b0;
    ring_we   = 1'b0;
    mac_clear = 1'b1;
    mac_en    = 1'b0;
    // A strobe outside IDLE is dropped and flagged one cycle later.
    overrun_d = ready && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          ring_we  = 1'b1;
          wr_ptr_d = wr_ptr_q + 5'd1;
          band_d   = 3'd0;
          tap_d    = 5'd0;
        end else begin
          ring_we  = 1'b0;
        end
      end
      ST_RUN: begin
        mac_clear = 1'b0;
        mac_en    = 1'b1;
        if (last_tap) tap_d = 5'd0; else tap_d = tap_q + 5'd1;
      end
      ST_FLUSH: begin
        // acc_sum already includes the final product; the MAC clears for the next band.
        y_d       = fit_y(32'(acc_sum), SAT_EN);
        y_band_d  = band_q;
        y_valid_d = 1'b1;
        if (last_band) band_d = 3'd0; else band_d = band_q + 3'd1;
      end
      default: begin
        mac_clear = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_RUN) band_sel_d = band_d; else band_sel_d = 3'd0;
  end

  // Counter and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= 5'd0;
      tap_q      <= 5'd0;
      band_q     <= 3'd0;
      band_sel_q <= 3'd0;
      y_q        <= 18'd0;
      y_band_q   <= 3'd0;
      y_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      tap_q      <= tap_d;
      band_q     <= band_d;
      band_sel_q <= band_sel_d;
      y_q        <= y_d;
      y_band_q   <= y_band_d;
      y_valid_q  <= y_valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  // Sample ring; cleared on reset so a fresh start sees silence history.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RING_DEPTH; i++) ring_q[i] <= {SAMPLE_W{1'b0}};
    end else if (ring_we) begin
      ring_q[wr_ptr_q] <= x;
    end else begin
      ring_q[wr_ptr_q] <= ring_q[wr_ptr_q];
    end
  end

  assign coeff_index = tap_q;
  assign band_sel    = band_sel_q;
  assign y           = y_q;
  assign y_band      = y_band_q;
  assign y_valid     = y_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule
